rx_char_sequencer: RTL and testbench
====================================

RX_CHAR_SEQUENCER -- requirements
Module: rx_char_sequencer

Interface
REQ-001 SHALL have ports: posedge_clk in 1, the single receive clock; rx_resetn in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: char_valid in 1, one-cycle strobe marking a newly latched character; char_is_control in 1, 1 = 4-bit control character, 0 = 10-bit data character.
REQ-003 SHALL have ports: control_p_r in 3, bits [1:0] carry the control code (00 FCT, 01 EOP, 10 EEP, 11 ESC); dta_timec_p in 9, bit [8] is the flag and bits [7:0] are data; parity_ok in 1, parity check result for the strobed character.
REQ-004 SHALL have ports: fct_sent in 1, strobe meaning the local transmitter issued one FCT; rx_fifo_full in 1.
REQ-005 SHALL have outputs: rx_fifo_wr_en out 1; rx_fifo_wdata out 9; rx_got_null out 1; rx_got_fct out 1; rx_got_time_code out 1; rx_time_out out 8.
REQ-006 SHALL have outputs: rx_first_null out 1 (sticky); rx_error_parity out 1; rx_error_esc out 1; rx_error_credit out 1; rx_credit out 6.

Function
REQ-007 SHALL register every output; each response appears exactly 1 cycle after the char_valid edge that causes it.
REQ-008 SHALL implement a 3-state FSM with states WAIT_NULL, NORMAL and ESC_SEEN; the reset state is WAIT_NULL.
REQ-009 WAIT_NULL: SHALL ignore all characters except ESC, which moves the FSM to ESC_SEEN while rx_first_null=0.
REQ-010 ESC_SEEN, next character is FCT: SHALL pulse rx_got_null, set rx_first_null, and go to NORMAL.
REQ-011 ESC_SEEN, next character is data: SHALL pulse rx_got_time_code and set rx_time_out=dta_timec_p[7:0], then go to NORMAL; if rx_first_null=0, SHALL drop the character and return to WAIT_NULL.
REQ-012 ESC_SEEN, next character is ESC, EOP or EEP: SHALL set rx_error_esc when rx_first_null=1; otherwise SHALL return to WAIT_NULL without error.
REQ-013 NORMAL: FCT SHALL pulse rx_got_fct; ESC SHALL move to ESC_SEEN.
REQ-014 NORMAL: a data character SHALL produce rx_fifo_wdata={1'b0,data}; EOP SHALL produce 9'h100; EEP SHALL produce 9'h101. Each of these is an N-char and pulses rx_fifo_wr_en.
REQ-015 Once rx_first_null=1, SHALL set rx_error_parity on any char_valid with parity_ok=0 and discard that character; the FSM state is held.
REQ-016 Credit: rx_credit 0..56; fct_sent adds 8 only if rx_credit<=48, otherwise no change; each accepted N-char subtracts 1.
REQ-017 fct_sent coincident with an N-char SHALL net +7, or -1 if the add is blocked.
REQ-018 An N-char arriving with rx_credit=0 or rx_fifo_full=1 SHALL set rx_error_credit and suppress rx_fifo_wr_en; rx_credit is unchanged.
REQ-019 Error flags and rx_first_null SHALL be sticky until reset; after any error is set, rx_fifo_wr_en SHALL stay 0.
REQ-020 char_valid=0 SHALL hold state, credit and sticky outputs; all pulse outputs SHALL return to 0.

Reset
REQ-021 While rx_resetn=0, all outputs SHALL be 0 and the FSM SHALL be WAIT_NULL; assertion mid-character aborts any ESC_SEEN sequence immediately.
REQ-022 Deassertion SHALL be synchronized externally; the first char_valid after release is processed normally.

Configuration
REQ-023 With RX_TIMECODE_EN defined, time-codes SHALL follow REQ-011.
REQ-024 Without RX_TIMECODE_EN, ESC+data SHALL still be consumed and return to NORMAL, while rx_got_time_code and rx_time_out are tied to 0.

Structure
REQ-025 Package rx_seq_pkg SHALL hold the control-code constants, the FSM state encoding, CREDIT_MAX=56, CREDIT_STEP=8, and the EOP/EEP FIFO codes.
REQ-026 Credit arithmetic SHALL live in sub-module rx_credit_counter.

Verification
REQ-027 Reset, then ESC,FCT -> rx_got_null pulse, rx_first_null=1, state NORMAL.
REQ-028 After NULL, fct_sent, then data 8'hA5 -> wr_en pulse, wdata=9'h0A5, rx_credit 8->7.
REQ-029 After NULL, ESC then data 8'h3F -> rx_got_time_code pulse and rx_time_out=8'h3F; without RX_TIMECODE_EN both stay 0.
REQ-030 After NULL, ESC,EOP -> rx_error_esc=1 and no FIFO write; the same sequence before the first NULL -> no error.
REQ-031 rx_credit=0, then an EOP -> rx_error_credit=1 and no write; 7x fct_sent -> rx_credit=56, and an 8th -> still 56.
REQ-032 After NULL, a character with parity_ok=0 -> rx_error_parity=1; with parity_ok=0 before the first NULL -> no flag.

Source files
------------

// File: rtl/rx_char_sequencer_pkg.sv
// Shared constants for the receive character sequencer: control codes, FSM
// encoding, credit limits and the FIFO words used for end-of-packet markers.
package rx_seq_pkg;

  localparam logic [1:0] CTRL_FCT = 2'b00;
  localparam logic [1:0] CTRL_EOP = 2'b01;
  localparam logic [1:0] CTRL_EEP = 2'b10;
  localparam logic [1:0] CTRL_ESC = 2'b11;

  typedef enum logic [1:0] {
    WAIT_NULL = 2'b00,
    NORMAL    = 2'b01,
    ESC_SEEN  = 2'b10
  } rx_state_e;

  localparam logic [5:0] CREDIT_MAX  = 6'd56;
  localparam logic [5:0] CREDIT_STEP = 6'd8;

  localparam logic [8:0] FIFO_EOP = 9'h100;
  localparam logic [8:0] FIFO_EEP = 9'h101;

  // A full credit step only fits while the count leaves room below the ceiling.
  function automatic logic credit_can_add(input logic [5:0] credit);
    return (credit <= (CREDIT_MAX - CREDIT_STEP));
  endfunction

endpackage

// File: rtl/rx_char_sequencer_if.sv
// Character strobe bus from the receive decoder into the sequencer.
interface rx_char_sequencer_if;

  logic       char_valid;
  logic       char_is_control;
  logic [2:0] control_p_r;
  logic [8:0] dta_timec_p;
  logic       parity_ok;

  modport master (
    output char_valid, char_is_control, control_p_r, dta_timec_p, parity_ok
  );

  modport slave (
    input char_valid, char_is_control, control_p_r, dta_timec_p, parity_ok
  );

endinterface

// File: rtl/rx_char_sequencer_credit.sv
// Receive credit counter: +8 per FCT issued (while it fits under 56), -1 per
// accepted N-char; both in one cycle net to +7 or -1.
module rx_credit_counter
  import rx_seq_pkg::*;
(
  input  logic       posedge_clk,
  input  logic       rx_resetn,
  input  logic       fct_sent,
  input  logic       nchar_taken,
  output logic [5:0] rx_credit
);

  logic [5:0] credit_r;
  logic [5:0] credit_nxt_s;

  // Next credit value from the add/subtract requests of this cycle.
  always_comb begin
    credit_nxt_s = credit_r;
    if (fct_sent && credit_can_add(credit_r)) begin
      if (nchar_taken) begin
        credit_nxt_s = credit_r + CREDIT_STEP - 6'd1;
      end else begin
        credit_nxt_s = credit_r + CREDIT_STEP;
      end
    end else if (nchar_taken) begin
      credit_nxt_s = credit_r - 6'd1;
    end else begin
      credit_nxt_s = credit_r;
    end
  end

  // Credit register.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      credit_r <= 6'd0;
    end else begin
      credit_r <= credit_nxt_s;
    end
  end

  assign rx_credit = credit_r;

endmodule

// File: rtl/rx_char_sequencer.sv
// Receive character sequencer: NULL detection, time-codes, N-char forwarding
// with credit tracking and sticky errors. Optional macro: RX_TIMECODE_EN.
module rx_char_sequencer
  import rx_seq_pkg::*;
(
  input  logic                posedge_clk,
  input  logic                rx_resetn,
  rx_char_sequencer_if.slave  char_if,
  input  logic                fct_sent,
  input  logic                rx_fifo_full,
  output logic                rx_fifo_wr_en,
  output logic [8:0]          rx_fifo_wdata,
  output logic                rx_got_null,
  output logic                rx_got_fct,
  output logic                rx_got_time_code,
  output logic [7:0]          rx_time_out,
  output logic                rx_first_null,
  output logic                rx_error_parity,
  output logic                rx_error_esc,
  output logic                rx_error_credit,
  output logic [5:0]          rx_credit
);

  rx_state_e  state_r, state_nxt_s;
  logic       first_null_r, first_null_nxt_s;
  logic       err_parity_r, err_parity_nxt_s;
  logic       err_esc_r, err_esc_nxt_s;
  logic       err_credit_r, err_credit_nxt_s;
  logic       got_null_r, got_null_nxt_s;
  logic       got_fct_r, got_fct_nxt_s;
  logic       got_tc_r, got_tc_nxt_s;
  logic       wr_en_r, wr_en_nxt_s;
  logic [8:0] wdata_r, wdata_nxt_s;
  logic [7:0] time_out_r, time_out_nxt_s;

  logic       is_ctrl_s, is_fct_s, is_esc_s, err_any_s, accept_s;
  logic [1:0] code_s;
  logic [7:0] data_s;
  logic [8:0] nchar_word_s;
  logic [5:0] credit_s;
  logic       unused_s;

  assign is_ctrl_s = char_if.char_is_control;
  assign code_s    = char_if.control_p_r[1:0];
  assign data_s    = char_if.dta_timec_p[7:0];
  assign is_fct_s  = is_ctrl_s && (code_s == CTRL_FCT);
  assign is_esc_s  = is_ctrl_s && (code_s == CTRL_ESC);
  assign err_any_s = err_parity_r | err_esc_r | err_credit_r;
  assign unused_s  = ^{char_if.control_p_r[2], char_if.dta_timec_p[8]};

  // FIFO word for the N-char currently on the bus.
  always_comb begin
    if (!is_ctrl_s) begin
      nchar_word_s = {1'b0, data_s};
    end else begin
      case (code_s)
        CTRL_EOP: nchar_word_s = FIFO_EOP;
        CTRL_EEP: nchar_word_s = FIFO_EEP;
        default:  nchar_word_s = 9'h000;
      endcase
    end
  end

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_nxt_s      = state_r;
    first_null_nxt_s = first_null_r;
    err_parity_nxt_s = err_parity_r;
    err_esc_nxt_s    = err_esc_r;
    err_credit_nxt_s = err_credit_r;
    got_null_nxt_s   = 1'b0;
    got_fct_nxt_s    = 1'b0;
    got_tc_nxt_s     = 1'b0;
    wr_en_nxt_s      = 1'b0;
    wdata_nxt_s      = wdata_r;
    time_out_nxt_s   = time_out_r;
    accept_s         = 1'b0;
    if (char_if.char_valid) begin
      if (first_null_r && !char_if.parity_ok) begin
        err_parity_nxt_s = 1'b1;
      end else begin
        case (state_r)
          WAIT_NULL: begin
            if (is_esc_s) state_nxt_s = ESC_SEEN;
            else          state_nxt_s = WAIT_NULL;
          end
          ESC_SEEN: begin
            if (!is_ctrl_s) begin
              if (first_null_r) begin
                state_nxt_s = NORMAL;
`ifdef RX_TIMECODE_EN
                got_tc_nxt_s   = 1'b1;
                time_out_nxt_s = data_s;
`else
                got_tc_nxt_s   = 1'b0;
                time_out_nxt_s = 8'h00;
`endif
              end else begin
                state_nxt_s = WAIT_NULL;
              end
            end else if (is_fct_s) begin
              got_null_nxt_s   = 1'b1;
              first_null_nxt_s = 1'b1;
              state_nxt_s      = NORMAL;
            end else if (first_null_r) begin
              err_esc_nxt_s = 1'b1;
              state_nxt_s   = NORMAL;
            end else begin
              state_nxt_s = WAIT_NULL;
            end
          end
          NORMAL: begin
            if (is_fct_s) begin
              got_fct_nxt_s = 1'b1;
            end else if (is_esc_s) begin
              state_nxt_s = ESC_SEEN;
            end else if ((credit_s == 6'd0) || rx_fifo_full) begin
              err_credit_nxt_s = 1'b1;
            end else if (!err_any_s) begin
              accept_s    = 1'b1;
              wr_en_nxt_s = 1'b1;
              wdata_nxt_s = nchar_word_s;
            end else begin
              accept_s = 1'b0;
            end
          end
          default: state_nxt_s = WAIT_NULL;
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state_r      <= WAIT_NULL;
      first_null_r <= 1'b0;
      err_parity_r <= 1'b0;
      err_esc_r    <= 1'b0;
      err_credit_r <= 1'b0;
      got_null_r   <= 1'b0;
      got_fct_r    <= 1'b0;
      got_tc_r     <= 1'b0;
      wr_en_r      <= 1'b0;
      wdata_r      <= 9'h000;
      time_out_r   <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      first_null_r <= first_null_nxt_s;
      err_parity_r <= err_parity_nxt_s;
      err_esc_r    <= err_esc_nxt_s;
      err_credit_r <= err_credit_nxt_s;
      got_null_r   <= got_null_nxt_s;
      got_fct_r    <= got_fct_nxt_s;
      got_tc_r     <= got_tc_nxt_s;
      wr_en_r      <= wr_en_nxt_s;
      wdata_r      <= wdata_nxt_s;
      time_out_r   <= time_out_nxt_s;
    end
  end

  rx_credit_counter u_credit (
    .posedge_clk (posedge_clk),
    .rx_resetn   (rx_resetn),
    .fct_sent    (fct_sent),
    .nchar_taken (accept_s),
    .rx_credit   (credit_s)
  );

  assign rx_fifo_wr_en    = wr_en_r;
  assign rx_fifo_wdata    = wdata_r;
  assign rx_got_null      = got_null_r;
  assign rx_got_fct       = got_fct_r;
  assign rx_got_time_code = got_tc_r;
  assign rx_time_out      = time_out_r;
  assign rx_first_null    = first_null_r;
  assign rx_error_parity  = err_parity_r;
  assign rx_error_esc     = err_esc_r;
  assign rx_error_credit  = err_credit_r;
  assign rx_credit        = credit_s;

endmodule

// File: tb/tb_rx_char_sequencer.sv
// Randomized bench for rx_char_sequencer with a character-level reference model.
module tb_rx_char_sequencer;

`ifdef RX_TIMECODE_EN
  localparam bit TC_EN = 1'b1;
`else
  localparam bit TC_EN = 1'b0;
`endif

  localparam int K_DATA = 0;
  localparam int K_FCT  = 1;
  localparam int K_EOP  = 2;
  localparam int K_EEP  = 3;
  localparam int K_ESC  = 4;

  logic       posedge_clk = 1'b0;
  logic       rx_resetn;
  logic       fct_sent;
  logic       rx_fifo_full;
  logic       rx_fifo_wr_en;
  logic [8:0] rx_fifo_wdata;
  logic       rx_got_null;
  logic       rx_got_fct;
  logic       rx_got_time_code;
  logic [7:0] rx_time_out;
  logic       rx_first_null;
  logic       rx_error_parity;
  logic       rx_error_esc;
  logic       rx_error_credit;
  logic [5:0] rx_credit;

  rx_char_sequencer_if char_if ();

  always #5 posedge_clk = ~posedge_clk;

  rx_char_sequencer dut (
    .posedge_clk      (posedge_clk),
    .rx_resetn        (rx_resetn),
    .char_if          (char_if),
    .fct_sent         (fct_sent),
    .rx_fifo_full     (rx_fifo_full),
    .rx_fifo_wr_en    (rx_fifo_wr_en),
    .rx_fifo_wdata    (rx_fifo_wdata),
    .rx_got_null      (rx_got_null),
    .rx_got_fct       (rx_got_fct),
    .rx_got_time_code (rx_got_time_code),
    .rx_time_out      (rx_time_out),
    .rx_first_null    (rx_first_null),
    .rx_error_parity  (rx_error_parity),
    .rx_error_esc     (rx_error_esc),
    .rx_error_credit  (rx_error_credit),
    .rx_credit        (rx_credit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: link synchronisation, pending escape, sticky flags, credit count.
  bit       m_null, m_esc, m_err_par, m_err_esc, m_err_cr;
  int       m_credit;
  bit [8:0] m_wdata;
  bit [7:0] m_time;
  bit       e_wr, e_null, e_fct, e_tc;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph);
    check_value({ph, ".wr_en"},      32'(rx_fifo_wr_en),    32'(e_wr));
    check_value({ph, ".wdata"},      32'(rx_fifo_wdata),    32'(m_wdata));
    check_value({ph, ".got_null"},   32'(rx_got_null),      32'(e_null));
    check_value({ph, ".got_fct"},    32'(rx_got_fct),       32'(e_fct));
    check_value({ph, ".got_tc"},     32'(rx_got_time_code), 32'(e_tc));
    check_value({ph, ".time_out"},   32'(rx_time_out),      32'(m_time));
    check_value({ph, ".first_null"}, 32'(rx_first_null),    32'(m_null));
    check_value({ph, ".err_parity"}, 32'(rx_error_parity),  32'(m_err_par));
    check_value({ph, ".err_esc"},    32'(rx_error_esc),     32'(m_err_esc));
    check_value({ph, ".err_credit"}, 32'(rx_error_credit),  32'(m_err_cr));
    check_value({ph, ".credit"},     32'(rx_credit),        32'(m_credit));
  endtask

  task automatic model_reset();
    m_null = 1'b0; m_esc = 1'b0; m_err_par = 1'b0; m_err_esc = 1'b0; m_err_cr = 1'b0;
    m_credit = 0; m_wdata = 9'h000; m_time = 8'h00;
    e_wr = 1'b0; e_null = 1'b0; e_fct = 1'b0; e_tc = 1'b0;
  endtask

  task automatic model_step(input bit valid, input int kind, input bit [7:0] data,
                            input bit par, input bit fct, input bit full);
    int take;
    take = 0;
    e_wr = 1'b0; e_null = 1'b0; e_fct = 1'b0; e_tc = 1'b0;
    if (valid) begin
      if (m_null && !par) begin
        m_err_par = 1'b1;
      end else if (m_esc) begin
        m_esc = 1'b0;
        if (kind == K_FCT) begin
          e_null = 1'b1;
          m_null = 1'b1;
        end else if (kind == K_DATA) begin
          if (m_null && TC_EN) begin
            e_tc   = 1'b1;
            m_time = data;
          end
        end else if (m_null) begin
          m_err_esc = 1'b1;
        end
      end else if (kind == K_ESC) begin
        m_esc = 1'b1;
      end else if (m_null) begin
        if (kind == K_FCT) begin
          e_fct = 1'b1;
        end else if (m_credit == 0 || full) begin
          m_err_cr = 1'b1;
        end else if (!(m_err_par || m_err_esc || m_err_cr)) begin
          e_wr = 1'b1;
          take = 1;
          case (kind)
            K_EOP:   m_wdata = 9'h100;
            K_EEP:   m_wdata = 9'h101;
            default: m_wdata = {1'b0, data};
          endcase
        end
      end
    end
    if (fct && (m_credit + 8 <= 56)) m_credit = m_credit + 8;
    m_credit = m_credit - take;
  endtask

  // Drive one cycle of stimulus at the falling edge, then check at the next falling edge.
  task automatic send(input string ph, input bit valid, input int kind, input bit [7:0] data,
                      input bit par, input bit fct, input bit full);
    logic [2:0] junk_ctrl;
    junk_ctrl = 3'($urandom_range(0, 7));
    char_if.char_valid      = valid;
    char_if.char_is_control = (kind != K_DATA);
    case (kind)
      K_FCT:   char_if.control_p_r = {junk_ctrl[2], 2'b00};
      K_EOP:   char_if.control_p_r = {junk_ctrl[2], 2'b01};
      K_EEP:   char_if.control_p_r = {junk_ctrl[2], 2'b10};
      K_ESC:   char_if.control_p_r = {junk_ctrl[2], 2'b11};
      default: char_if.control_p_r = junk_ctrl;
    endcase
    char_if.dta_timec_p = {1'($urandom_range(0, 1)), data};
    char_if.parity_ok   = par;
    fct_sent            = fct;
    rx_fifo_full        = full;
    model_step(valid, kind, data, par, fct, full);
    @(posedge posedge_clk);
    @(negedge posedge_clk);
    check_outputs(ph);
  endtask

  task automatic chr(input string ph, input int kind, input bit [7:0] data);
    send(ph, 1'b1, kind, data, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string ph);
    rx_resetn            = 1'b0;
    char_if.char_valid   = 1'b0;
    fct_sent             = 1'b0;
    rx_fifo_full         = 1'b0;
    #1;
    model_reset();
    check_outputs(ph);
    @(negedge posedge_clk);
    rx_resetn = 1'b1;
  endtask

  initial begin
    char_if.char_is_control = 1'b0;
    char_if.control_p_r     = 3'b000;
    char_if.dta_timec_p     = 9'h000;
    char_if.parity_ok       = 1'b1;
    do_reset("reset");

    chr("null_esc", K_ESC, 8'h00);
    chr("null_fct", K_FCT, 8'h00);
    chr("normal_fct", K_FCT, 8'h00);
    send("fct_sent", 1'b0, K_DATA, 8'h00, 1'b1, 1'b1, 1'b0);
    chr("data_a5", K_DATA, 8'hA5);
    chr("tc_esc", K_ESC, 8'h00);
    chr("tc_data", K_DATA, 8'h3F);
    chr("eop_ok", K_EOP, 8'h00);
    chr("esc_eop_esc", K_ESC, 8'h00);
    chr("esc_eop_eop", K_EOP, 8'h00);
    chr("post_err_eop", K_EOP, 8'h00);

    do_reset("reset2");
    chr("pre_esc", K_ESC, 8'h00);
    chr("pre_eop", K_EOP, 8'h00);
    chr("pre_esc2", K_ESC, 8'h00);
    chr("pre_data", K_DATA, 8'h12);
    chr("null2_esc", K_ESC, 8'h00);
    chr("null2_fct", K_FCT, 8'h00);
    chr("credit0_eop", K_EOP, 8'h00);
    for (int i = 0; i < 8; i++) send("fct_fill", 1'b0, K_DATA, 8'h00, 1'b1, 1'b1, 1'b0);

    do_reset("reset3");
    send("pre_par", 1'b1, K_DATA, 8'h55, 1'b0, 1'b0, 1'b0);
    chr("null3_esc", K_ESC, 8'h00);
    send("null3_fct_badpar", 1'b1, K_FCT, 8'h00, 1'b0, 1'b0, 1'b0);
    chr("null3_fct", K_FCT, 8'h00);
    send("fct3", 1'b0, K_DATA, 8'h00, 1'b1, 1'b1, 1'b0);
    send("full_data", 1'b1, K_DATA, 8'h77, 1'b1, 1'b0, 1'b1);
    send("badpar", 1'b1, K_DATA, 8'h66, 1'b0, 1'b0, 1'b0);
    chr("post_par", K_DATA, 8'h01);

    do_reset("reset4");
    chr("mid_esc", K_ESC, 8'h00);
    do_reset("reset_mid");
    chr("after_mid_fct", K_FCT, 8'h00);

    for (int run = 0; run < 12; run++) begin
      do_reset("rnd_reset");
      if (run % 4 != 3) begin
        chr("rnd_esc", K_ESC, 8'h00);
        chr("rnd_fct", K_FCT, 8'h00);
        for (int j = 0; j < int'($urandom_range(0, 7)); j++)
          send("rnd_fill", 1'b0, K_DATA, 8'h00, 1'b1, 1'b1, 1'b0);
      end
      for (int c = 0; c < 150; c++) begin
        int sel, kind;
        sel = int'($urandom_range(0, 19));
        if (sel == 12 || sel == 13) kind = K_FCT;
        else if (sel == 14)         kind = K_EOP;
        else if (sel == 15)         kind = K_EEP;
        else if (sel == 16)         kind = K_ESC;
        else                        kind = K_DATA;
        send("rnd", ($urandom_range(0, 9) < 7), kind, 8'($urandom_range(0, 255)),
             ($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 29) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
